// File: rtl/sobel_linebuf_ctrl.sv
// sobel_linebuf_ctrl
//
// Controls the two line-buffer FIFOs that feed the Sobel edge-detection
// kernel, and builds the 3x3 pixel window the kernel works on.
//
// FIFO0 holds the previous image row and FIFO1 holds the row before that.
// Each accepted pixel reads the older rows out of the FIFOs. One cycle later
// the controller writes the pixel into FIFO0 and moves FIFO0's output into
// FIFO1. The live pixel and both FIFO outputs then shift into a registered
// 3x3 window. FIFO data is stale after reset and after each frame, so the
// controller drains both FIFOs before it accepts any new pixels.
//
// Parameters:
//   IMG_W  pixels per line (must not exceed the line-FIFO depth)
//   IMG_H  lines per frame (at least 3)
//   DW     pixel width
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   pix_in      input pixel
//   pix_vld     pix_in valid
//   pix_rdy     controller accepts pix_in (transfer on pix_vld && pix_rdy)
//   f0_din      FIFO0 write data
//   f0_wr_en    FIFO0 write enable
//   f0_rd_en    FIFO0 read enable
//   f0_dout     FIFO0 read data (valid one cycle after rd_en, held otherwise)
//   f0_empty    FIFO0 empty flag
//   f1_*        same set of signals for FIFO1
//   win         3x3 window, element (r,c) at win[DW*(3r+c) +: DW];
//               r=0 is the oldest row, c=0 is the oldest column
//   win_vld     one-cycle strobe, win holds a complete window
//   frame_done  one-cycle pulse after the last pixel of a frame is accepted

module sobel_linebuf_ctrl #(
  parameter int IMG_W = 200,
  parameter int IMG_H = 200,
  parameter int DW    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   pix_in,
  input  logic            pix_vld,
  output logic            pix_rdy,
  output logic [DW-1:0]   f0_din,
  output logic            f0_wr_en,
  output logic            f0_rd_en,
  input  logic [DW-1:0]   f0_dout,
  input  logic            f0_empty,
  output logic [DW-1:0]   f1_din,
  output logic            f1_wr_en,
  output logic            f1_rd_en,
  input  logic [DW-1:0]   f1_dout,
  input  logic            f1_empty,
  output logic [9*DW-1:0] win,
  output logic            win_vld,
  output logic            frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic {
    FLUSH = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic          s1_v;
  logic [DW-1:0] s1_pix;
  logic [RW-1:0] s1_row;
  logic [CW-1:0] s1_col;

  logic          accept;
  logic          last_pix;

  assign last_pix = (col == COL_LAST) && (row == ROW_LAST);

  // Pixels are accepted only in RUN.
  assign accept = (state == RUN) && pix_vld;

  // Each pixel is written one cycle after it is accepted. By then the
  // accept cycle has already read the older entry out, so a FIFO that holds
  // a full line is never written while full. FIFO1 receives whatever FIFO0
  // returned for the accept cycle, which is the pixel one row above.
  assign f0_wr_en = s1_v;
  assign f0_din   = s1_pix;
  assign f1_wr_en = s1_v && (s1_row >= RW'(1));
  assign f1_din   = f0_dout;

  // Next-state and read-enable logic.
  // FLUSH reads any FIFO that is not empty. It leaves for RUN once both
  // FIFOs are empty and no stage-1 write is still pending. The FLUSH reads
  // are held off while rst is high, so all enables stay low during reset
  // even if the FIFOs still contain data. In RUN, a FIFO is read only when
  // it already holds a row older than the current one.
  always_comb begin
    state_nxt = state;
    pix_rdy   = 1'b0;
    f0_rd_en  = 1'b0;
    f1_rd_en  = 1'b0;
    case (state)
      FLUSH: begin
        if (!rst) begin
          f0_rd_en = !f0_empty;
          f1_rd_en = !f1_empty;
        end
        if (f0_empty && f1_empty && !s1_v) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        pix_rdy = 1'b1;
        if (accept) begin
          f0_rd_en = (row >= RW'(1));
          f1_rd_en = (row >= RW'(2));
          if (last_pix) begin
            state_nxt = FLUSH;
          end
        end
      end
      default: begin
        state_nxt = FLUSH;
      end
    endcase
  end

  // State register. Reset always lands in FLUSH, because the FIFOs have no
  // reset and may still hold data from before.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FLUSH;
    end else begin
      state <= state_nxt;
    end
  end

  // Raster position of the next pixel to be accepted. When the last pixel
  // of a frame is accepted, both counters return to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Stage 1 holds the accepted pixel and its position for one cycle, so the
  // FIFO read data is ready when the window shifts. The pixel, row and
  // column hold their values during input gaps. Only s1_v drops back to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_pix <= '0;
      s1_row <= '0;
      s1_col <= '0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_pix <= pix_in;
        s1_row <= row;
        s1_col <= col;
      end
    end
  end

  // frame_done pulses one cycle after the last pixel of the frame is
  // accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && last_pix;
    end
  end

  // Window shift register. Each stage-1 pixel shifts the whole window one
  // column to the left. The new column comes from FIFO1 (two rows up), FIFO0
  // (one row up) and the live pixel. In the first two rows, the FIFO values
  // shifted in are not real pixels, so win_vld stays low for those
  // positions. win_vld also stays low for the first two columns of each row,
  // so no window ever crosses a row or frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win     <= '0;
      win_vld <= 1'b0;
    end else begin
      win_vld <= s1_v && (s1_row >= RW'(2)) && (s1_col >= CW'(2));
      if (s1_v) begin
        for (int r = 0; r < 3; r++) begin
          win[DW*(3*r)   +: DW] <= win[DW*(3*r+1) +: DW];
          win[DW*(3*r+1) +: DW] <= win[DW*(3*r+2) +: DW];
        end
        win[DW*2 +: DW] <= f1_dout;
        win[DW*5 +: DW] <= f0_dout;
        win[DW*8 +: DW] <= s1_pix;
      end
    end
  end

endmodule

// File: tb/tb_sobel_linebuf_ctrl.sv
// tb_sobel_linebuf_ctrl
//
// Directed testbench for sobel_linebuf_ctrl on a 5x4 image.
// Both line FIFOs are modelled with a depth of 200. The models have no reset
// and a registered read port. Each pixel record holds the pixel value and
// the window that pixel should produce. The bench builds the expected
// windows from the image geometry. A monitor collects every window strobe,
// and the collected windows are compared in order against the pixel table.

`timescale 1ns/1ps

module tb_sobel_linebuf_ctrl;

  localparam int IMG_W = 5;
  localparam int IMG_H = 4;
  localparam int DW    = 8;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NWIN  = (IMG_W - 2) * (IMG_H - 2);
  localparam int DEPTH = 200;
  localparam int WINW  = 9 * DW;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [DW-1:0]   pix_in = '0;
  logic            pix_vld = 1'b0;
  logic            pix_rdy;
  logic [DW-1:0]   f0_din, f1_din, f0_dout, f1_dout;
  logic            f0_wr_en, f0_rd_en, f1_wr_en, f1_rd_en;
  logic            f0_empty, f1_empty;
  logic [WINW-1:0] win;
  logic            win_vld;
  logic            frame_done;

  typedef struct {
    logic [DW-1:0]   pix;
    logic            exp_vld;
    logic [WINW-1:0] exp_win;
  } vec_t;

  vec_t            vecs [2][NPIX];
  int              acc_cyc [2][NPIX];

  int              tests = 0;
  int              fails = 0;
  int              cyc = 0;
  logic [WINW-1:0] got_win [$];
  int              got_cyc [$];
  int              fd_cyc [$];
  int              flush_len;
  int              leaks;
  int              last_acc;
  logic [WINW-1:0] w_tmp;

  logic [DW-1:0]   fmem [2][DEPTH];
  int              fcnt [2] = '{0, 0};
  int              frp [2] = '{0, 0};
  int              fwp [2] = '{0, 0};
  logic [DW-1:0]   fdout [2] = '{'0, '0};
  logic [DW-1:0]   fdin [2];
  logic [1:0]      fwr, frd;
  int              fovf = 0;
  int              funf = 0;
  int              fmax0 = 0;
  int              fmax1 = 0;

  assign fwr      = {f1_wr_en, f0_wr_en};
  assign frd      = {f1_rd_en, f0_rd_en};
  assign fdin[0]  = f0_din;
  assign fdin[1]  = f1_din;
  assign f0_dout  = fdout[0];
  assign f1_dout  = fdout[1];
  assign f0_empty = (fcnt[0] == 0);
  assign f1_empty = (fcnt[1] == 0);

  sobel_linebuf_ctrl #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .DW(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pix_in(pix_in),
    .pix_vld(pix_vld),
    .pix_rdy(pix_rdy),
    .f0_din(f0_din),
    .f0_wr_en(f0_wr_en),
    .f0_rd_en(f0_rd_en),
    .f0_dout(f0_dout),
    .f0_empty(f0_empty),
    .f1_din(f1_din),
    .f1_wr_en(f1_wr_en),
    .f1_rd_en(f1_rd_en),
    .f1_dout(f1_dout),
    .f1_empty(f1_empty),
    .win(win),
    .win_vld(win_vld),
    .frame_done(frame_done)
  );

  // The clock runs with a 10 ns period.
  always #5 clk = ~clk;

  // This cycle counter is the time base for the latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  // Line FIFO models. They have no reset, data is registered on read, and
  // the output holds when there is no read. A read from an empty FIFO or a
  // write to a full FIFO is recorded as a protocol error.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (frd[k]) begin
        if (fcnt[k] == 0) begin
          funf <= funf + 1;
        end else begin
          fdout[k] <= fmem[k][frp[k]];
          frp[k]   <= (frp[k] + 1) % DEPTH;
        end
      end
      if (fwr[k]) begin
        if (fcnt[k] == DEPTH) begin
          fovf <= fovf + 1;
        end else begin
          fmem[k][fwp[k]] <= fdin[k];
          fwp[k]          <= (fwp[k] + 1) % DEPTH;
        end
      end
      fcnt[k] <= fcnt[k] + ((fwr[k] && fcnt[k] != DEPTH) ? 1 : 0)
                         - ((frd[k] && fcnt[k] != 0) ? 1 : 0);
    end
  end

  // The monitor samples on the falling edge. It records window strobes,
  // frame_done pulses and the peak FIFO occupancy.
  always @(negedge clk) begin
    if (win_vld) begin
      got_win.push_back(win);
      got_cyc.push_back(cyc);
    end
    if (frame_done) begin
      fd_cyc.push_back(cyc);
    end
    if (fcnt[0] > fmax0) fmax0 <= fcnt[0];
    if (fcnt[1] > fmax1) fmax1 <= fcnt[1];
  end

  // The watchdog stops a run that hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [WINW-1:0] act,
                             input logic [WINW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Each pixel is base + 16*row + col. A pixel at column 2 or later in row 2
  // or later should produce the 3x3 neighbourhood whose newest corner is
  // that pixel.
  task automatic fill_table(input int slot, input int base);
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        int              i;
        logic [WINW-1:0] w;
        i = r * IMG_W + c;
        w = '0;
        vecs[slot][i].pix     = DW'(base + 16 * r + c);
        vecs[slot][i].exp_vld = (r >= 2) && (c >= 2);
        if (vecs[slot][i].exp_vld) begin
          for (int wr = 0; wr < 3; wr++) begin
            for (int wc = 0; wc < 3; wc++) begin
              w[DW*(3*wr+wc) +: DW] = DW'(base + 16 * (r - 2 + wr) + (c - 2 + wc));
            end
          end
        end
        vecs[slot][i].exp_win = w;
      end
    end
  endtask

  // Call this right after a falling edge. It can first insert a few random
  // idle cycles. It then holds the pixel until the DUT takes it, and records
  // the cycle in which the pixel was accepted.
  task automatic send_pixel(input int slot, input int idx, input bit gaps);
    int waited;
    bit done;
    waited = 0;
    done   = 1'b0;
    if (gaps) begin
      for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
        pix_vld = 1'b0;
        @(negedge clk);
      end
    end
    pix_in  = vecs[slot][idx].pix;
    pix_vld = 1'b1;
    while (!done && waited < 100) begin
      if (pix_rdy) begin
        acc_cyc[slot][idx] = cyc;
        done = 1'b1;
      end else begin
        waited++;
      end
      @(negedge clk);
    end
    if (!done) begin
      checkOutput($sformatf("accept_timeout pixel %0d", idx), WINW'(0), WINW'(1));
    end
  endtask

  task automatic applyStimulus(input int slot, input int base, input bit gaps);
    fill_table(slot, base);
    for (int i = 0; i < NPIX; i++) begin
      send_pixel(slot, i, gaps);
    end
    pix_vld = 1'b0;
  endtask

  // Counts the cycles with pix_rdy low, starting from the current falling
  // edge.
  task automatic measure_flush(output int len);
    len = 0;
    while (!pix_rdy && len < 50) begin
      len++;
      @(negedge clk);
    end
  endtask

  // Compares the strobes collected from index start onward, in order,
  // against the windows expected for one frame.
  task automatic check_frame(input int slot, input int start, input string name);
    int k;
    k = start;
    for (int i = 0; i < NPIX; i++) begin
      if (vecs[slot][i].exp_vld) begin
        if (k < got_win.size()) begin
          checkOutput($sformatf("%s window px%0d", name, i), got_win[k],
                      vecs[slot][i].exp_win);
          checkOutput($sformatf("%s latency px%0d", name, i),
                      WINW'(got_cyc[k] - acc_cyc[slot][i]), WINW'(2));
        end else begin
          checkOutput($sformatf("%s missing window px%0d", name, i), WINW'(0), WINW'(1));
        end
        k++;
      end
    end
  endtask

  initial begin
    // Reset with empty FIFOs: everything stays low, and FLUSH lasts one cycle.
    #1 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset pix_rdy", WINW'(pix_rdy), WINW'(0));
      checkOutput("reset win", win, WINW'(0));
      checkOutput("reset win_vld/frame_done", WINW'({win_vld, frame_done}), WINW'(0));
      checkOutput("reset fifo enables",
                  WINW'({f0_wr_en, f0_rd_en, f1_wr_en, f1_rd_en}), WINW'(0));
    end
    rst = 1'b0;
    #1;
    checkOutput("post-reset flush pix_rdy", WINW'(pix_rdy), WINW'(0));
    checkOutput("post-reset flush rd_en", WINW'({f0_rd_en, f1_rd_en}), WINW'(0));
    @(negedge clk);
    checkOutput("post-reset run pix_rdy", WINW'(pix_rdy), WINW'(1));

    // Continuous frame: check every window, latency, frame_done and the
    // end-of-frame drain.
    got_win.delete(); got_cyc.delete(); fd_cyc.delete();
    applyStimulus(0, 'h00, 1'b0);
    last_acc = acc_cyc[0][NPIX-1];
    measure_flush(flush_len);
    checkOutput("frameA flush length", WINW'(flush_len), WINW'(IMG_W + 1));
    checkOutput("frameA fifo0 drained", WINW'(fcnt[0]), WINW'(0));
    checkOutput("frameA fifo1 drained", WINW'(fcnt[1]), WINW'(0));
    repeat (2) @(negedge clk);
    check_frame(0, 0, "frameA");
    checkOutput("frameA strobe count", WINW'(got_win.size()), WINW'(NWIN));
    w_tmp = 72'h22_21_20_12_11_10_02_01_00;
    checkOutput("frameA first window",
                (got_win.size() > 0) ? got_win[0] : WINW'(0), w_tmp);
    w_tmp = (got_win.size() == NWIN) ? got_win[NWIN-1] : '0;
    checkOutput("frameA last center", WINW'(w_tmp[DW*4 +: DW]),
                WINW'(16 * (IMG_H - 2) + (IMG_W - 2)));
    checkOutput("frameA frame_done count", WINW'(fd_cyc.size()), WINW'(1));
    checkOutput("frameA frame_done cycle",
                WINW'((fd_cyc.size() > 0) ? fd_cyc[0] : -1), WINW'(last_acc + 1));

    // Same image with random input gaps. The windows must not change.
    got_win.delete(); got_cyc.delete(); fd_cyc.delete();
    applyStimulus(1, 'h00, 1'b1);
    measure_flush(flush_len);
    checkOutput("frameB flush length", WINW'(flush_len), WINW'(IMG_W + 1));
    repeat (2) @(negedge clk);
    check_frame(1, 0, "frameB");
    checkOutput("frameB strobe count", WINW'(got_win.size()), WINW'(NWIN));
    checkOutput("frameB frame_done count", WINW'(fd_cyc.size()), WINW'(1));

    // Reset in the middle of row 2. The clear is asynchronous, the partial
    // FIFO data gets drained, and the next frame matches the clean frame.
    fill_table(0, 'h00);
    for (int i = 0; i < 2 * IMG_W + 2; i++) begin
      send_pixel(0, i, 1'b0);
    end
    pix_vld = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset pix_rdy", WINW'(pix_rdy), WINW'(0));
    checkOutput("async reset win", win, WINW'(0));
    checkOutput("async reset win_vld/frame_done", WINW'({win_vld, frame_done}), WINW'(0));
    checkOutput("async reset fifo enables",
                WINW'({f0_wr_en, f0_rd_en, f1_wr_en, f1_rd_en}), WINW'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    measure_flush(flush_len);
    checkOutput("mid-reset fifo0 drained", WINW'(fcnt[0]), WINW'(0));
    checkOutput("mid-reset fifo1 drained", WINW'(fcnt[1]), WINW'(0));
    got_win.delete(); got_cyc.delete(); fd_cyc.delete();
    applyStimulus(0, 'h00, 1'b0);
    measure_flush(flush_len);
    repeat (2) @(negedge clk);
    check_frame(0, 0, "afterReset");
    checkOutput("afterReset strobe count", WINW'(got_win.size()), WINW'(NWIN));

    // Two frames back to back. The second frame's windows must not contain
    // any pixel from the first frame.
    got_win.delete(); got_cyc.delete(); fd_cyc.delete();
    applyStimulus(0, 'h00, 1'b0);
    applyStimulus(1, 'h80, 1'b0);
    measure_flush(flush_len);
    repeat (2) @(negedge clk);
    checkOutput("b2b strobe count", WINW'(got_win.size()), WINW'(2 * NWIN));
    check_frame(0, 0, "b2b frame1");
    check_frame(1, NWIN, "b2b frame2");
    leaks = 0;
    for (int k = NWIN; k < 2 * NWIN && k < got_win.size(); k++) begin
      w_tmp = got_win[k];
      for (int e = 0; e < 9; e++) begin
        if (w_tmp[DW*e +: DW] < 8'h80) leaks++;
      end
    end
    checkOutput("b2b frame2 leakage", WINW'(leaks), WINW'(0));
    checkOutput("b2b frame_done count", WINW'(fd_cyc.size()), WINW'(2));

    // FIFO protocol checks across the whole run.
    checkOutput("fifo write while full", WINW'(fovf), WINW'(0));
    checkOutput("fifo read while empty", WINW'(funf), WINW'(0));
    checkOutput("fifo0 peak occupancy <= IMG_W", WINW'(fmax0 <= IMG_W), WINW'(1));
    checkOutput("fifo1 peak occupancy <= IMG_W", WINW'(fmax1 <= IMG_W), WINW'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
